// File: rtl/bank_rejestrow_if.sv
// Register bank access bus: one write port, two read ports and the clear
// control, bundled between the instruction decoder and the bank.
//   master : decoder side, drives addresses/enables/data and clr
//   slave  : bank side, returns rdata_a/b, valid_a/b and busy
interface bank_rejestrow_if #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 3
);
   logic             we;
   logic [SEL_W-1:0] waddr;
   logic [WIDTH-1:0] wdata;
   logic             re_a;
   logic             re_b;
   logic [SEL_W-1:0] raddr_a;
   logic [SEL_W-1:0] raddr_b;
   logic [WIDTH-1:0] rdata_a;
   logic [WIDTH-1:0] rdata_b;
   logic             valid_a;
   logic             valid_b;
   logic             clr;
   logic             busy;

   modport master (
      output we, waddr, wdata, re_a, re_b, raddr_a, raddr_b, clr,
      input  rdata_a, rdata_b, valid_a, valid_b, busy
   );

   modport slave (
      input  we, waddr, wdata, re_a, re_b, raddr_a, raddr_b, clr,
      output rdata_a, rdata_b, valid_a, valid_b, busy
   );
endinterface

// File: rtl/bank_rejestrow.sv
// Parametrised register bank: DEPTH registers of WIDTH bits, one write port,
// two independently enabled registered read ports with same-cycle
// write-to-read bypass, and a one-register-per-cycle hardware clear sweep.
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high, overrides everything
//   bus  : bank_rejestrow_if.slave (write/read ports, clr, busy)
// All outputs come straight from flops.
module bank_rejestrow #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int SEL_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   bank_rejestrow_if.slave   bus
);
   localparam int CNT_W = $clog2(DEPTH);
   localparam int NPORT = 2;

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t                        state_q, state_nxt;
   logic [CNT_W-1:0]              cnt_q;
   logic                          busy_q;
   logic [DEPTH-1:0][WIDTH-1:0]   mem_q;
   logic                          accept, sweeping, wr_en, last;

   logic [NPORT-1:0]              re;
   logic [NPORT-1:0][SEL_W-1:0]   raddr;
   logic [NPORT-1:0][WIDTH-1:0]   rdata_q;
   logic [NPORT-1:0]              valid_q;

   // Extra top bit so DEPTH == 2**SEL_W compares correctly.
   function automatic logic in_range(input logic [SEL_W-1:0] a);
      return {1'b0, a} < (SEL_W+1)'(DEPTH);
   endfunction

   assign last = (cnt_q == CNT_W'(DEPTH-1));

   // ---- FSM: state register ----
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_nxt;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (bus.clr) state_nxt = CLEAR;
         CLEAR:   if (last)    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      accept   = 1'b0;
      sweeping = 1'b0;
      case (state_q)
         IDLE:    accept   = 1'b1;
         CLEAR:   sweeping = 1'b1;
         default: accept   = 1'b0;
      endcase
      wr_en = accept & bus.we & in_range(bus.waddr);
   end

   // Sweep pointer sits at 0 whenever not sweeping, so entering CLEAR
   // starts from register 0 without extra load logic.
   always_ff @(posedge clk) begin
      if (rst || !sweeping || last) cnt_q <= '0;
      else                          cnt_q <= cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= 1'b0;
      else     busy_q <= (state_nxt == CLEAR);
   end

   // Write and sweep never coincide: writes only happen in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && bus.waddr == SEL_W'(i))   mem_q[i] <= bus.wdata;
            if (sweeping && cnt_q == CNT_W'(i))    mem_q[i] <= '0;
         end
      end
   end

   assign re    = {bus.re_b, bus.re_a};
   assign raddr = {bus.raddr_b, bus.raddr_a};

   for (genvar p = 0; p < NPORT; p++) begin : g_port
      logic [WIDTH-1:0] rd_val;
      logic [WIDTH-1:0] rdata_r;
      logic             valid_r;
      logic             rd_en;

      assign rd_en = accept & re[p];

      // Out-of-range addresses match no entry and read as 0; a same-cycle
      // write to the read address forwards the new data.
      always_comb begin
         rd_val = '0;
         for (int i = 0; i < DEPTH; i++)
            if (raddr[p] == SEL_W'(i)) rd_val = mem_q[i];
         if (bus.we && bus.waddr == raddr[p] && in_range(raddr[p]))
            rd_val = bus.wdata;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            rdata_r <= '0;
            valid_r <= 1'b0;
         end else begin
            valid_r <= rd_en;
            if (rd_en) rdata_r <= rd_val;
         end
      end

      assign rdata_q[p] = rdata_r;
      assign valid_q[p] = valid_r;
   end

   assign bus.rdata_a = rdata_q[0];
   assign bus.rdata_b = rdata_q[1];
   assign bus.valid_a = valid_q[0];
   assign bus.valid_b = valid_q[1];
   assign bus.busy    = busy_q;
endmodule

// File: tb/tb_bank_rejestrow.sv
// Bench for bank_rejestrow: default 8x8 instance plus a 16-bit DEPTH=5
// instance. Reads push their expected data into per-port queues; a monitor
// on the falling edge pops and compares whenever a port raises valid.
module tb_bank_rejestrow;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bank_rejestrow_if #(.WIDTH(8),  .SEL_W(3)) bus0 ();
   bank_rejestrow_if #(.WIDTH(16), .SEL_W(3)) bus1 ();

   bank_rejestrow #(.WIDTH(8),  .DEPTH(8), .SEL_W(3)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   bank_rejestrow #(.WIDTH(16), .DEPTH(5), .SEL_W(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] q0[$], q1[$], q2[$], q3[$];

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic mon(input string nm, input logic v, input logic [15:0] d, input int idx);
      logic [15:0] e;
      int sz;
      if (v !== 1'b1) return;
      case (idx)
         0: sz = q0.size();
         1: sz = q1.size();
         2: sz = q2.size();
         default: sz = q3.size();
      endcase
      if (sz == 0) begin
         n_checks++;
         $display("FAIL %s: unexpected valid with data %h, nothing expected", nm, d);
         return;
      end
      case (idx)
         0: e = q0.pop_front();
         1: e = q1.pop_front();
         2: e = q2.pop_front();
         default: e = q3.pop_front();
      endcase
      check(nm, d, e);
   endtask

   always @(negedge clk) begin
      mon("d0.rdata_a", bus0.valid_a, 16'(bus0.rdata_a), 0);
      mon("d0.rdata_b", bus0.valid_b, 16'(bus0.rdata_b), 1);
      mon("d1.rdata_a", bus1.valid_a, bus1.rdata_a, 2);
      mon("d1.rdata_b", bus1.valid_b, bus1.rdata_b, 3);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access cycle on dut0: optional write, optional reads with expected data.
   task automatic cyc0(input bit we, input logic [2:0] wa, input logic [7:0] wd,
                       input bit ra, input logic [2:0] aa, input logic [7:0] ea,
                       input bit rb, input logic [2:0] ab, input logic [7:0] eb);
      bus0.we = we; bus0.waddr = wa; bus0.wdata = wd;
      bus0.re_a = ra; bus0.raddr_a = aa;
      bus0.re_b = rb; bus0.raddr_b = ab;
      if (ra) q0.push_back(16'(ea));
      if (rb) q1.push_back(16'(eb));
      tick();
      bus0.we = 1'b0; bus0.re_a = 1'b0; bus0.re_b = 1'b0;
   endtask

   task automatic cyc1(input bit we, input logic [2:0] wa, input logic [15:0] wd,
                       input bit ra, input logic [2:0] aa, input logic [15:0] ea,
                       input bit rb, input logic [2:0] ab, input logic [15:0] eb);
      bus1.we = we; bus1.waddr = wa; bus1.wdata = wd;
      bus1.re_a = ra; bus1.raddr_a = aa;
      bus1.re_b = rb; bus1.raddr_b = ab;
      if (ra) q2.push_back(ea);
      if (rb) q3.push_back(eb);
      tick();
      bus1.we = 1'b0; bus1.re_a = 1'b0; bus1.re_b = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      int n;
      bus0.we = 0; bus0.waddr = 0; bus0.wdata = 0; bus0.re_a = 0; bus0.re_b = 0;
      bus0.raddr_a = 0; bus0.raddr_b = 0; bus0.clr = 0;
      bus1.we = 0; bus1.waddr = 0; bus1.wdata = 0; bus1.re_a = 0; bus1.re_b = 0;
      bus1.raddr_a = 0; bus1.raddr_b = 0; bus1.clr = 0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;

      // Reset state
      check("rst d0.rdata_a", 16'(bus0.rdata_a), 16'h0);
      check("rst d0.valid_a", 16'(bus0.valid_a), 16'h0);
      check("rst d0.valid_b", 16'(bus0.valid_b), 16'h0);
      check("rst d0.busy",    16'(bus0.busy),    16'h0);
      check("rst d1.busy",    16'(bus1.busy),    16'h0);

      // Every register reads 0 before any write
      for (int i = 0; i < 8; i++) cyc0(0, 0, 0, 0, 0, 0, 1, 3'(i), 8'h00);

      // Basic write then read
      cyc0(1, 3, 8'hA5, 0, 0, 0, 0, 0, 0);
      cyc0(0, 0, 0, 1, 3, 8'hA5, 0, 0, 0);

      // Bypass on both ports, then a normal read of the new value
      cyc0(1, 5, 8'h11, 0, 0, 0, 0, 0, 0);
      cyc0(1, 5, 8'h3C, 1, 5, 8'h3C, 1, 5, 8'h3C);
      cyc0(0, 0, 0, 1, 5, 8'h3C, 0, 0, 0);

      // Hold: rdata stays, valid drops
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold d0.rdata_a", 16'(bus0.rdata_a), 16'h3C);
         check("hold d0.valid_a", 16'(bus0.valid_a), 16'h0);
      end

      // Clear sweep
      for (int i = 0; i < 8; i++) cyc0(1, 3'(i), 8'h10 + 8'(i), 0, 0, 0, 0, 0, 0);
      bus0.clr = 1'b1;
      tick();
      bus0.clr = 1'b0;
      check("clr d0.busy rise", 16'(bus0.busy), 16'h1);
      n = 0;
      while (bus0.busy === 1'b1 && n < 50) begin
         n++;
         if (n == 5) begin
            bus0.we = 1'b1; bus0.waddr = 3'd2; bus0.wdata = 8'hEE;
            bus0.re_a = 1'b1; bus0.raddr_a = 3'd7;
         end
         tick();
         if (n == 5) begin
            check("sweep d0.valid_a", 16'(bus0.valid_a), 16'h0);
            bus0.we = 1'b0; bus0.re_a = 1'b0;
         end
      end
      check("sweep d0.busy cycles", 16'(n), 16'd8);
      for (int i = 0; i < 8; i++) cyc0(0, 0, 0, 1, 3'(i), 8'h00, 0, 0, 0);

      // Reset in the middle of a sweep
      cyc0(1, 5, 8'h77, 0, 0, 0, 0, 0, 0);
      bus0.clr = 1'b1;
      tick();
      bus0.clr = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort d0.busy",    16'(bus0.busy),    16'h0);
      check("abort d0.rdata_a", 16'(bus0.rdata_a), 16'h0);
      cyc0(1, 6, 8'h5A, 0, 0, 0, 0, 0, 0);
      cyc0(0, 0, 0, 1, 6, 8'h5A, 1, 5, 8'h00);

      // DEPTH=5 instance: out-of-range accesses and short sweep
      cyc1(1, 6, 16'hBEEF, 0, 0, 0, 0, 0, 0);
      cyc1(0, 0, 0, 1, 6, 16'h0000, 0, 0, 0);
      cyc1(1, 4, 16'h1234, 0, 0, 0, 0, 0, 0);
      cyc1(0, 0, 0, 0, 0, 0, 1, 4, 16'h1234);
      cyc1(1, 6, 16'hABCD, 1, 6, 16'h0000, 1, 4, 16'h1234);
      cyc1(1, 4, 16'h5555, 0, 0, 0, 1, 4, 16'h5555);
      bus1.clr = 1'b1;
      tick();
      bus1.clr = 1'b0;
      n = 0;
      while (bus1.busy === 1'b1 && n < 50) begin
         n++;
         tick();
      end
      check("sweep d1.busy cycles", 16'(n), 16'd5);
      cyc1(0, 0, 0, 1, 4, 16'h0000, 0, 0, 0);

      tick(); tick();
      check("pending d0 reads", 16'(q0.size() + q1.size()), 16'h0);
      check("pending d1 reads", 16'(q2.size() + q3.size()), 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/bank_rejestrow.md
# bank_rejestrow

Parametrised register bank for the PLC datapath. It replaces a fixed 8×8 combinational register-select mux with WIDTH×DEPTH storage, one write port and two independently enabled registered read ports. It adds same-cycle write-to-read bypass and a multi-cycle hardware clear sequence with a busy flag. It sits between the instruction decoder (addresses, enables) and the ALU operand inputs.

## Interface
- WIDTH, 8, data width of each register
- DEPTH, 8, number of registers; any value ≥ 2, power of two not required
- SEL_W, 3, address width; must be ≥ ceil(log2(DEPTH))
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- we  in  1  write enable
- waddr  in  SEL_W  write address
- wdata  in  WIDTH  write data
- re_a / re_b  in  1  read enable, port A / B
- raddr_a / raddr_b  in  SEL_W  read address, port A / B
- rdata_a / rdata_b  out  WIDTH  registered read data
- valid_a / valid_b  out  1  rdata of that port updated this cycle
- clr  in  1  start clear sweep (single-cycle pulse or level)
- busy  out  1  clear sweep in progress

## Operation
- Reset (rst=1 at edge): all DEPTH registers ← 0, rdata_a/b ← 0, valid_a/b ← 0, busy ← 0, FSM ← IDLE, sweep counter ← 0. rst has priority over every other input.
- Write, IDLE only: we=1 and waddr < DEPTH → reg[waddr] ← wdata at edge. waddr ≥ DEPTH → dropped, no side effect.
- Read, per port, IDLE only: re=1 → rdata ← reg[raddr] at edge, valid ← 1. raddr ≥ DEPTH → rdata ← 0, valid ← 1.
- re=0: rdata holds its previous value, valid ← 0.
- Bypass: we=1, re=1, raddr == waddr < DEPTH in the same cycle → rdata ← wdata, the new value, not the stale one. Applies to both ports independently. Both ports may read the same address.
- FSM states: IDLE and CLEAR.
  - IDLE → CLEAR when clr=1. busy ← 1, counter ← 0.
  - CLEAR: each cycle reg[counter] ← 0, counter ← counter+1.
  - After clearing reg[DEPTH-1]: CLEAR → IDLE, busy ← 0, counter ← 0.
  - A clr and a we in the same IDLE cycle: the write is performed first, then the sweep starts. The sweep zeroes that register anyway.
- During CLEAR:
  - we is ignored.
  - re is ignored: valid ← 0, rdata holds.
  - clr is ignored; there is no restart.
- rst during CLEAR aborts the sweep immediately and clears everything (reset values above).

## Timing
- Read latency 1 cycle: address/enable sampled at edge N, rdata/valid visible after edge N.
- Write visible to a read issued in the same cycle via bypass. Writes are visible to later reads from the next cycle on.
- Clear sweep:
  - clr sampled at edge N → busy=1 after edge N.
  - reg[k] zeroed at edge N+1+k.
  - busy=0 after edge N+DEPTH; accesses are accepted again at edge N+DEPTH+1.
  - busy is high for exactly DEPTH cycles.
- No combinational path from any input to rdata, valid or busy; all outputs are flops.

## Test plan
- Reset/basic, default params: assert rst 1 cycle. Write 8'hA5 to reg 3, then the next cycle re_a=1, raddr_a=3 → rdata_a=8'hA5, valid_a=1 one cycle later. Before any write, rdata_b reads 0 from every address.
- Bypass, both ports: reg 5 holds 8'h11. In one cycle we=1, waddr=5, wdata=8'h3C, re_a=re_b=1, raddr_a=raddr_b=5 → next cycle rdata_a=rdata_b=8'h3C. A following read of 5 also returns 8'h3C.
- Hold/valid: after a read of 8'h3C, drop re_a for 3 cycles → rdata_a stays 8'h3C, valid_a=0 for all 3 cycles.
- Clear sweep: fill regs 0..7 with 8'h10..8'h17, pulse clr → busy high exactly 8 cycles. A we to reg 2 mid-sweep is dropped, and a read mid-sweep gives valid=0. After busy falls, all 8 registers read 0.
- Reset mid-sweep: pulse clr, assert rst at cycle 3 of the sweep → busy=0 and FSM=IDLE next cycle. A write to reg 6 followed by a read of reg 6 returns the written value normally.
- Non-power-of-two, DEPTH=5, SEL_W=3, WIDTH=16: write 16'hBEEF to addr 6 → dropped. A read of addr 6 returns 0 with valid=1. Addr 4 works normally. clr keeps busy high for exactly 5 cycles.
